// File: rtl/bus_map_pkg.sv
// Shared bus map: device slot order, slot count, collector state encoding and default timeout.
package bus_map_pkg;

    localparam int BOOT  = 0;
    localparam int SDRAM = 1;
    localparam int GPU   = 2;
    localparam int PS2   = 3;
    localparam int GPIO  = 4;
    localparam int HEX   = 5;
    localparam int TEST  = 6;
    localparam int SD    = 7;
    localparam int XV6   = 8;
    localparam int UART  = 9;
    localparam int PLIC  = 10;
    localparam int SYN32 = 11;
    localparam int SYN16 = 12;

    localparam int N_DEV           = 13;
    localparam int DEFAULT_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } coll_state_t;

endpackage

// File: rtl/bus_response_collector_onehot_mux32.sv
// Stateless AND-OR read-data mux: each 32-bit slot is gated by its own select bit.
module onehot_mux32 #(
    parameter int N_DEV = bus_map_pkg::N_DEV
) (
    input  logic [N_DEV-1:0]    sel,
    input  logic [N_DEV*32-1:0] data,
    output logic [31:0]         y
);

    // No priority: a malformed select ORs slots together rather than picking one.
    always_comb begin
        y = '0;
        for (int k = 0; k < N_DEV; k++) begin
            y = y | (data[32*k +: 32] & {32{sel[k]}});
        end
    end

endmodule

// File: rtl/bus_response_collector.sv
// Bus return path: latches the decoder select, strobes the chosen device, waits for its
// completion (or a timeout) and hands read data back to the CPU with a single done pulse.
module bus_response_collector #(
    parameter int N_DEV   = bus_map_pkg::N_DEV,
    parameter int TIMEOUT = bus_map_pkg::DEFAULT_TIMEOUT,
    parameter int CW      = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req,
    input  logic                i_write,
    input  logic [N_DEV-1:0]    i_dv,
    output logic [N_DEV-1:0]    o_dev_req,
    output logic                o_dev_write,
    input  logic [N_DEV-1:0]    i_dev_done,
    input  logic [N_DEV*32-1:0] i_dev_data,
    output logic [31:0]         o_data,
    output logic                o_done,
    output logic                o_fault,
    output logic                o_busy
);

    import bus_map_pkg::*;

    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    coll_state_t      state, state_nxt;
    logic [N_DEV-1:0] sel;
    logic             wr;
    logic             fault;
    logic [CW-1:0]    cnt;
    logic [31:0]      rdata_p0;

    logic accept, bad_sel, hit, take, expire;

    function automatic logic is_onehot(input logic [N_DEV-1:0] v);
        return (v != '0) && ((v & (v - N_DEV'(1))) == '0);
    endfunction

    onehot_mux32 #(.N_DEV(N_DEV)) u_mux (
        .sel  (sel),
        .data (i_dev_data),
        .y    (rdata_p0)
    );

    assign hit         = |(i_dev_done & sel);
    assign o_busy      = (state != ST_IDLE);
    assign o_dev_write = wr;

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        bad_sel   = 1'b0;
        take      = 1'b0;
        expire    = 1'b0;
        o_dev_req = '0;
        unique case (state)
            ST_IDLE: begin
                if (i_req) begin
                    accept    = 1'b1;
                    bad_sel   = !is_onehot(i_dv);
                    state_nxt = bad_sel ? ST_RESP : ST_STROBE;
                end
            end
            ST_STROBE: begin
                o_dev_req = sel;
                take      = hit;
                state_nxt = hit ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (hit) begin
                    take      = 1'b1;
                    state_nxt = ST_RESP;
                end else if (cnt >= TO_LAST) begin
                    expire    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
        endcase
    end

    // Strobe cycle is counted as the first elapsed cycle of the timeout budget.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sel     <= '0;
            wr      <= 1'b0;
            fault   <= 1'b0;
            cnt     <= '0;
            o_data  <= '0;
            o_done  <= 1'b0;
            o_fault <= 1'b0;
        end else begin
            o_done  <= (state == ST_RESP);
            o_fault <= (state == ST_RESP) && fault;
            if (accept) begin
                sel   <= i_dv;
                wr    <= i_write;
                fault <= bad_sel;
            end
            if (state == ST_STROBE)    cnt <= CW'(1);
            else if (state == ST_WAIT) cnt <= cnt + CW'(1);
            if (take) begin
                o_data <= rdata_p0;
                fault  <= 1'b0;
            end else if (expire) begin
                o_data <= '0;
                fault  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_response_collector.sv
// Directed bench for bus_response_collector with a short timeout (TIMEOUT=8).
module tb_bus_response_collector;

    localparam int N = 13;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_req = 1'b0;
    logic            i_write = 1'b0;
    logic [N-1:0]    i_dv = '0;
    logic [N-1:0]    o_dev_req;
    logic            o_dev_write;
    logic [N-1:0]    i_dev_done = '0;
    logic [N*32-1:0] i_dev_data;
    logic [31:0]     o_data;
    logic            o_done;
    logic            o_fault;
    logic            o_busy;

    int n_chk  = 0;
    int n_pass = 0;

    bus_response_collector #(.N_DEV(N), .TIMEOUT(8), .CW(10)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_write     (i_write),
        .i_dv        (i_dv),
        .o_dev_req   (o_dev_req),
        .o_dev_write (o_dev_write),
        .i_dev_done  (i_dev_done),
        .i_dev_data  (i_dev_data),
        .o_data      (o_data),
        .o_done      (o_done),
        .o_fault     (o_fault),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Issues one request in the current cycle T and observes cycles T+1..T+budget.
    // done_at: cycle offset at which done_bits are driven (<=0: never); req2_at: extra i_req offset.
    task automatic access(input logic [N-1:0] dv, input logic wr, input int done_at,
                          input logic [N-1:0] done_bits, input int req2_at, input int budget,
                          output int done_cyc, output logic flt, output logic [31:0] dat,
                          output int n_strobe, output logic [N-1:0] strobe_v,
                          output logic wr_seen, output logic saw_slot5);
        done_cyc = -1; flt = 1'b0; dat = '0; n_strobe = 0; strobe_v = '0;
        wr_seen = 1'b0; saw_slot5 = 1'b0;
        i_req = 1'b1; i_write = wr; i_dv = dv;
        for (int k = 1; k <= budget; k++) begin
            @(posedge i_clk);
            #1;
            i_req      = (k == req2_at);
            i_dev_done = (k == done_at) ? done_bits : '0;
            if (k == 1) wr_seen = o_dev_write;
            if (o_dev_req != '0) begin
                n_strobe++;
                strobe_v = o_dev_req;
            end
            if (o_data == 32'hD0D0_0005) saw_slot5 = 1'b1;
            if (o_done) begin
                done_cyc = k;
                flt      = o_fault;
                dat      = o_data;
                break;
            end
        end
        i_req = 1'b0; i_dev_done = '0; i_write = 1'b0;
    endtask

    initial begin
        int          dc, ns;
        logic        f, ws, s5;
        logic [31:0] d;
        logic [N-1:0] sv;
        int          n_done, n_busy, n_str;

        for (int k = 0; k < N; k++)
            i_dev_data[32*k +: 32] = (k == 9) ? 32'h0000_00A5 : (32'hD0D0_0000 | 32'(k));

        step(3);
        i_rst = 1'b0;
        step(1);
        chk("rst_done",  32'(o_done), 0);
        chk("rst_fault", 32'(o_fault), 0);
        chk("rst_busy",  32'(o_busy), 0);
        chk("rst_req",   32'(o_dev_req), 0);
        chk("rst_data",  o_data, 0);
        chk("rst_wr",    32'(o_dev_write), 0);

        // Mapped UART read, done two cycles after the strobe.
        access(13'(1 << 9), 1'b0, 3, 13'(1 << 9), -1, 20, dc, f, d, ns, sv, ws, s5);
        chk("rd_lat",    32'(dc), 5);
        chk("rd_fault",  32'(f), 0);
        chk("rd_data",   d, 32'h0000_00A5);
        chk("rd_nstrb",  32'(ns), 1);
        chk("rd_strbv",  32'(sv), 32'(1 << 9));
        step(2);

        // GPIO write, device done in the strobe cycle.
        access(13'(1 << 4), 1'b1, 1, 13'(1 << 4), -1, 20, dc, f, d, ns, sv, ws, s5);
        chk("wr_lat",    32'(dc), 3);
        chk("wr_flag",   32'(ws), 1);
        chk("wr_fault",  32'(f), 0);
        chk("wr_data",   d, 32'hD0D0_0004);
        step(2);

        // Unmapped: fault, no strobe, o_data untouched.
        access('0, 1'b0, -1, '0, -1, 20, dc, f, d, ns, sv, ws, s5);
        chk("unm_lat",   32'(dc), 2);
        chk("unm_fault", 32'(f), 1);
        chk("unm_nstrb", 32'(ns), 0);
        chk("unm_data",  d, 32'hD0D0_0004);
        step(2);

        // Timeout on GPIO with no done.
        access(13'(1 << 4), 1'b0, -1, '0, -1, 20, dc, f, d, ns, sv, ws, s5);
        chk("to_lat",    32'(dc), 10);
        chk("to_fault",  32'(f), 1);
        chk("to_data",   d, 0);
        chk("to_nstrb",  32'(ns), 1);
        step(2);

        // Two selects at once.
        access(13'h0003, 1'b0, -1, '0, -1, 20, dc, f, d, ns, sv, ws, s5);
        chk("multi_lat",   32'(dc), 2);
        chk("multi_fault", 32'(f), 1);
        chk("multi_nstrb", 32'(ns), 0);
        step(2);

        // SDRAM selected, only slot 5 reports done.
        access(13'(1 << 1), 1'b0, 3, 13'(1 << 5), -1, 20, dc, f, d, ns, sv, ws, s5);
        chk("wrong_lat",   32'(dc), 10);
        chk("wrong_fault", 32'(f), 1);
        chk("wrong_data",  d, 0);
        chk("wrong_slot5", 32'(s5), 0);
        step(2);

        // Same-cycle done plus a second request during RESP.
        access(13'(1 << 9), 1'b0, 1, 13'(1 << 9), 2, 20, dc, f, d, ns, sv, ws, s5);
        chk("same_lat",   32'(dc), 3);
        chk("same_fault", 32'(f), 0);
        chk("same_data",  d, 32'h0000_00A5);
        chk("same_nstrb", 32'(ns), 1);
        n_str = 0; n_busy = 0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (o_dev_req != '0) n_str++;
            if (o_busy) n_busy++;
        end
        chk("drop_strb", 32'(n_str), 0);
        chk("drop_busy", 32'(n_busy), 0);

        // Reset while in WAIT, then a late done from the abandoned device.
        i_req = 1'b1; i_write = 1'b1; i_dv = 13'(1 << 1);
        step(1);
        i_req = 1'b0; i_write = 1'b0;
        step(2);
        i_rst = 1'b1;
        step(1);
        i_rst = 1'b0;
        i_dev_done = 13'(1 << 1);
        n_done = 0; n_busy = 0; n_str = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            i_dev_done = '0;
            if (o_done) n_done++;
            if (o_busy) n_busy++;
            if (o_dev_req != '0) n_str++;
        end
        chk("mrst_done",  32'(n_done), 0);
        chk("mrst_busy",  32'(n_busy), 0);
        chk("mrst_strb",  32'(n_str), 0);
        chk("mrst_data",  o_data, 0);
        chk("mrst_fault", 32'(o_fault), 0);
        chk("mrst_wr",    32'(o_dev_write), 0);

        access(13'(1 << 9), 1'b0, 2, 13'(1 << 9), -1, 20, dc, f, d, ns, sv, ws, s5);
        chk("post_lat",   32'(dc), 4);
        chk("post_fault", 32'(f), 0);
        chk("post_data",  d, 32'h0000_00A5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
